// File: rtl/progmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : progmem_bridge
//  Purpose  : Bridges the Z80 memory bus to the boot-loaded program RAM.
//             Holds the CPU in reset until the RAM is loaded, decodes reads
//             in the program window, stretches them with wait_n to cover the
//             RAM's one-cycle read latency and returns the captured byte.
//  Revision : 1.0 - initial release
// ============================================================================
module progmem_bridge #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MEM_LOG2  = 12,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                mreq_n,
  input  logic                rd_n,
  input  logic                wr_n,
  input  logic [15:0]         cpu_addr,
  output logic [7:0]          cpu_din,
  output logic                wait_n,
  output logic                cpu_n_reset,
  output logic                wr_err,
  output logic                ram_ce,
  output logic [MEM_LOG2-1:0] ram_addr,
  input  logic [7:0]          ram_dout,
  input  logic                ram_loaded
);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_IDLE    = 3'd1,
    S_FETCH   = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]          r_cpu_din;
  logic                r_wait_n;
  logic                r_cpu_n_reset;
  logic                r_wr_err;
  logic                r_ram_ce;
  logic [MEM_LOG2-1:0] r_ram_addr;

  logic [7:0]          w_din_nxt;
  logic                w_wait_n_nxt;
  logic                w_cpu_n_reset_nxt;
  logic                w_wr_err_nxt;
  logic                w_ce_nxt;
  logic [MEM_LOG2-1:0] w_addr_nxt;

  logic [15:0]         w_offset;
  logic                w_hit;
  logic                w_rdreq;
  logic                w_wrreq;

  // Window decode: the subtraction wraps, so addresses below a nonzero base
  // become large offsets and fall outside the window.
  assign w_offset = cpu_addr - BASE_ADDR;
  assign w_hit    = ((w_offset >> MEM_LOG2) == 16'd0);
  assign w_rdreq  = ~mreq_n & ~rd_n;
  assign w_wrreq  = ~mreq_n & ~wr_n;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt       = r_state;
    w_din_nxt         = r_cpu_din;
    w_wait_n_nxt      = r_wait_n;
    w_cpu_n_reset_nxt = r_cpu_n_reset;
    w_wr_err_nxt      = 1'b0;
    w_ce_nxt          = 1'b0;
    w_addr_nxt        = r_ram_addr;
    case (r_state)
      S_BOOT: begin
        w_cpu_n_reset_nxt = 1'b0;
        if (ram_loaded) begin
          w_state_nxt       = S_IDLE;
          w_cpu_n_reset_nxt = 1'b1;
        end
      end
      S_IDLE: begin
        // A simultaneous read and write strobe is served as a plain read.
        if (w_rdreq) begin
          if (w_hit) begin
            w_state_nxt  = S_FETCH;
            w_ce_nxt     = 1'b1;
            w_addr_nxt   = w_offset[MEM_LOG2-1:0];
            w_wait_n_nxt = 1'b0;
          end else begin
            w_state_nxt = S_HOLD;
            w_din_nxt   = OPEN_BUS;
          end
        end else if (w_wrreq) begin
          // The program RAM is read-only once booted: flag, do not access.
          w_state_nxt  = S_HOLD;
          w_wr_err_nxt = w_hit;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt  = S_HOLD;
        w_din_nxt    = ram_dout;
        w_wait_n_nxt = 1'b1;
      end
      S_HOLD: begin
        // One RAM access per CPU cycle: wait for mreq_n to deassert.
        if (mreq_n) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= S_BOOT;
      r_cpu_din     <= OPEN_BUS;
      r_wait_n      <= 1'b1;
      r_cpu_n_reset <= 1'b0;
      r_wr_err      <= 1'b0;
      r_ram_ce      <= 1'b0;
      r_ram_addr    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cpu_din     <= w_din_nxt;
      r_wait_n      <= w_wait_n_nxt;
      r_cpu_n_reset <= w_cpu_n_reset_nxt;
      r_wr_err      <= w_wr_err_nxt;
      r_ram_ce      <= w_ce_nxt;
      r_ram_addr    <= w_addr_nxt;
    end
  end

  assign cpu_din     = r_cpu_din;
  assign wait_n      = r_wait_n;
  assign cpu_n_reset = r_cpu_n_reset;
  assign wr_err      = r_wr_err;
  assign ram_ce      = r_ram_ce;
  assign ram_addr    = r_ram_addr;

endmodule
`default_nettype wire

// File: tb/tb_progmem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_progmem_bridge
//  Purpose  : Self-checking bench for progmem_bridge with a behavioural
//             synchronous RAM and a read-data scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_progmem_bridge;

  logic        clk;
  logic        n_reset;
  logic        mreq_n;
  logic        rd_n;
  logic        wr_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        wait_n;
  logic        cpu_n_reset;
  logic        wr_err;
  logic        ram_ce;
  logic [11:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_loaded;

  logic [7:0]  mem [0:4095];
  logic [7:0]  exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  progmem_bridge #(
    .BASE_ADDR(16'h0000),
    .MEM_LOG2 (12),
    .OPEN_BUS (8'hFF)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .mreq_n     (mreq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .wait_n     (wait_n),
    .cpu_n_reset(cpu_n_reset),
    .wr_err     (wr_err),
    .ram_ce     (ram_ce),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .ram_loaded (ram_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model: data valid the cycle after ce is sampled,
  // junk otherwise so a mistimed capture is visible.
  always @(posedge clk) begin
    if (ram_ce) ram_dout <= mem[ram_addr];
    else        ram_dout <= 8'hC3;
  end

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (cpu_n_reset !== 1'b0) begin n_errors++; $display("FAIL rst_cpu_n_reset got %b exp 0", cpu_n_reset); end
    n_checks++; if (wait_n !== 1'b1) begin n_errors++; $display("FAIL rst_wait_n got %b exp 1", wait_n); end
    n_checks++; if (ram_ce !== 1'b0) begin n_errors++; $display("FAIL rst_ram_ce got %b exp 0", ram_ce); end
    n_checks++; if (ram_addr !== 12'h000) begin n_errors++; $display("FAIL rst_ram_addr got %h exp 000", ram_addr); end
    n_checks++; if (cpu_din !== 8'hFF) begin n_errors++; $display("FAIL rst_cpu_din got %h exp FF", cpu_din); end
    n_checks++; if (wr_err !== 1'b0) begin n_errors++; $display("FAIL rst_wr_err got %b exp 0", wr_err); end
  endtask

  // Boot hold: a read is even attempted while unloaded; nothing may move.
  task automatic test_boot();
    int bad = 0;
    n_reset = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (i >= 100 && i < 110) begin mreq_n = 1'b0; rd_n = 1'b0; cpu_addr = 16'h0010; end
      else begin mreq_n = 1'b1; rd_n = 1'b1; end
      if (cpu_n_reset !== 1'b0 || ram_ce !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL boot_hold got %0d bad cycles exp 0", bad); end
    @(negedge clk);
    ram_loaded = 1'b1;
    #1;
    n_checks++; if (cpu_n_reset !== 1'b0) begin n_errors++; $display("FAIL boot_early got %b exp 0", cpu_n_reset); end
    @(negedge clk);
    n_checks++; if (cpu_n_reset !== 1'b1) begin n_errors++; $display("FAIL boot_release got %b exp 1", cpu_n_reset); end
  endtask

  // mode: 0 read, 1 write, 2 read+write strobes together.
  // keep: negedges the request stays asserted; total: negedges observed.
  task automatic do_access(input logic [15:0] addr, input int mode, input int keep,
                           input int total, input string name);
    int          ce_cnt = 0;
    int          wait_lo = 0;
    int          err_cnt = 0;
    logic [11:0] ce_addr = 12'h000;
    logic [7:0]  din_rise = 8'h00;
    bit          rose = 0;
    logic        prev_wait = 1'b1;
    logic [15:0] off;
    bit          hit;
    bit          is_rd;
    logic [7:0]  exp;
    off   = addr - 16'h0000;
    hit   = (off < 16'h1000);
    is_rd = (mode != 1);
    @(negedge clk);
    cpu_addr = addr;
    mreq_n   = 1'b0;
    rd_n     = (mode == 1);
    wr_n     = (mode == 0);
    if (is_rd) exp_q.push_back(hit ? mem[off[11:0]] : 8'hFF);
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (ram_ce) begin ce_cnt++; ce_addr = ram_addr; end
      if (!wait_n) wait_lo++;
      if (wr_err) err_cnt++;
      if (wait_n && !prev_wait && !rose) begin rose = 1; din_rise = cpu_din; end
      prev_wait = wait_n;
      if (i + 1 == keep) begin mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; end
    end
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    if (ram_ce) ce_cnt++;
    if (wr_err) err_cnt++;
    n_checks++;
    if (ce_cnt != ((is_rd && hit) ? 1 : 0)) begin
      n_errors++; $display("FAIL %s ce_pulses got %0d exp %0d", name, ce_cnt, (is_rd && hit) ? 1 : 0);
    end
    n_checks++;
    if (wait_lo != ((is_rd && hit) ? 2 : 0)) begin
      n_errors++; $display("FAIL %s wait_low got %0d exp %0d", name, wait_lo, (is_rd && hit) ? 2 : 0);
    end
    n_checks++;
    if (err_cnt != ((mode == 1 && hit) ? 1 : 0)) begin
      n_errors++; $display("FAIL %s wr_err got %0d exp %0d", name, err_cnt, (mode == 1 && hit) ? 1 : 0);
    end
    if (is_rd && hit) begin
      n_checks++;
      if (ce_addr !== off[11:0]) begin n_errors++; $display("FAIL %s ram_addr got %h exp %h", name, ce_addr, off[11:0]); end
    end
    if (is_rd) begin
      exp = exp_q.pop_front();
      if (hit) begin
        n_checks++;
        if (!rose || din_rise !== exp) begin
          n_errors++; $display("FAIL %s din_at_wait_rise got %h (rose %0d) exp %h", name, din_rise, rose, exp);
        end
      end
      n_checks++;
      if (cpu_din !== exp) begin n_errors++; $display("FAIL %s cpu_din got %h exp %h", name, cpu_din, exp); end
    end
  endtask

  task automatic test_read_hit();
    do_access(16'h0123, 0, 4, 4, "read_0123");
    do_access(16'h0456, 0, 4, 4, "read_0456");
  endtask

  task automatic test_boundary();
    do_access(16'h0FFF, 0, 4, 4, "read_0FFF");
    do_access(16'h1000, 0, 4, 4, "read_1000");
    do_access(16'h0000, 0, 4, 4, "read_0000");
    do_access(16'hFFFF, 0, 4, 4, "read_FFFF");
  endtask

  task automatic test_write();
    logic [7:0] din_before;
    din_before = cpu_din;
    do_access(16'h0040, 1, 4, 4, "write_0040");
    n_checks++;
    if (cpu_din !== din_before) begin n_errors++; $display("FAIL write_din_kept got %h exp %h", cpu_din, din_before); end
    do_access(16'h8000, 1, 4, 4, "write_8000");
    do_access(16'h0200, 2, 4, 4, "rd_wr_both");
  endtask

  task automatic test_back_to_back();
    do_access(16'h0321, 0, 9, 9, "hold_long");
    do_access(16'h0321, 0, 4, 4, "hold_rereq");
  endtask

  task automatic test_drop();
    do_access(16'h0777, 0, 1, 4, "drop_fetch");
    do_access(16'h0778, 0, 4, 4, "after_drop");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cpu_addr = 16'h0123; mreq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (ram_ce !== 1'b1) begin n_errors++; $display("FAIL mid_in_fetch ram_ce got %b exp 1", ram_ce); end
    n_reset = 1'b0; ram_loaded = 1'b0;
    #1;
    n_checks++;
    if ({cpu_n_reset, wait_n, ram_ce, ram_addr, cpu_din, wr_err} !== {1'b0, 1'b1, 1'b0, 12'h000, 8'hFF, 1'b0}) begin
      n_errors++;
      $display("FAIL mid_reset_outputs got nrst=%b wait=%b ce=%b addr=%h din=%h err=%b exp 0 1 0 000 FF 0",
               cpu_n_reset, wait_n, ram_ce, ram_addr, cpu_din, wr_err);
    end
    mreq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    n_checks++; if (cpu_n_reset !== 1'b0) begin n_errors++; $display("FAIL reboot_hold got %b exp 0", cpu_n_reset); end
    ram_loaded = 1'b1;
    @(negedge clk);
    n_checks++; if (cpu_n_reset !== 1'b1) begin n_errors++; $display("FAIL reboot_release got %b exp 1", cpu_n_reset); end
    do_access(16'h0123, 0, 4, 4, "read_after_reboot");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3) ^ 8'h5A;
    mem[12'h123] = 8'h3E;
    mem[12'hFFF] = 8'h81;
    mem[12'h000] = 8'h17;
    n_reset    = 1'b0;
    mreq_n     = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    cpu_addr   = 16'h0000;
    ram_loaded = 1'b0;
    ram_dout   = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_boot();
    test_read_hit();
    test_boundary();
    test_write();
    test_back_to_back();
    test_drop();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin n_errors++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/progmem_bridge.md
Name: progmem_bridge

Overview:
- Sits directly downstream of the 4 KB boot-loaded program RAM, between it and the Z80 core's memory bus.
- Holds the CPU in reset until the RAM reports `loaded`.
- Decodes CPU read cycles that fall in the program window and drives the RAM's `ce`/`addr`.
- Stretches each such CPU read with `wait_n` to cover the RAM's one-cycle synchronous read latency, then captures the RAM data byte and presents it on the CPU data-in bus.

Parameters:
- BASE_ADDR, 16'h0000, CPU address of program-RAM byte 0.
- MEM_LOG2, 12, log2 of the window size in bytes (the RAM address width).
- OPEN_BUS, 8'hFF, value returned for unmapped reads.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_reset  in  1  asynchronous active-low reset.
- mreq_n  in  1  CPU memory request, active low.
- rd_n  in  1  CPU read strobe, active low.
- wr_n  in  1  CPU write strobe, active low.
- cpu_addr  in  16  CPU address bus.
- cpu_din  out  8  data returned to the CPU (registered).
- wait_n  out  1  CPU wait request, active low (registered).
- cpu_n_reset  out  1  CPU reset, active low (registered).
- wr_err  out  1  one-cycle pulse on a write to the program window.
- ram_ce  out  1  program-RAM chip enable, active high (registered).
- ram_addr  out  MEM_LOG2  program-RAM byte address (registered).
- ram_dout  in  8  program-RAM read data; valid the cycle after `ram_ce` is sampled.
- ram_loaded  in  1  program-RAM load complete.

Behaviour:
- Reset (asynchronous, n_reset=0) values:
  - state=BOOT, cpu_n_reset=0, wait_n=1, ram_ce=0, ram_addr=0, cpu_din=OPEN_BUS, wr_err=0.
  - Reset mid-access abandons the access immediately.
- Window hit ("hit"): cpu_addr - BASE_ADDR < 2^MEM_LOG2, computed unsigned over 16 bits with wrap. ram_addr = (cpu_addr - BASE_ADDR)[MEM_LOG2-1:0].
- Read request ("rdreq"): mreq_n=0 and rd_n=0.
- Write request ("wrreq"): mreq_n=0 and wr_n=0.
- BOOT state:
  - cpu_n_reset=0, ram_ce=0.
  - When ram_loaded=1: go to IDLE; cpu_n_reset=1 from the next cycle.
  - ram_loaded returning to 0 is treated as unreachable; no recovery is defined.
- IDLE state:
  - rdreq and hit at edge t: ram_addr latched, ram_ce=1, wait_n=0 from t+1; go to FETCH.
  - rdreq and not hit: cpu_din=OPEN_BUS, wait_n stays 1; go to HOLD.
  - wrreq and hit: wr_err=1 for exactly one cycle (RAM is read-only after boot), no RAM access; go to HOLD.
  - wrreq and not hit: no action; go to HOLD.
  - rd_n and wr_n both 0: treated as a read; wr_err is not raised.
- FETCH state (RAM sampling the address):
  - ram_ce=0 from the next cycle; go to CAPTURE.
- CAPTURE state:
  - At edge t+2: cpu_din<=ram_dout, wait_n=1; go to HOLD.
  - Read latency from request edge to data valid and wait released: 2 cycles.
- HOLD state:
  - Stay while mreq_n=0.
  - On mreq_n=1, go to IDLE. cpu_din keeps its last value.
  - A new request needs mreq_n to deassert first, so each CPU cycle gets exactly one RAM access.
- wait_n is 0 only in FETCH and CAPTURE.
- ram_ce is high for exactly one cycle per hit read.
- Request dropped while in FETCH or CAPTURE (mreq_n=1): the access still completes, then returns to IDLE via HOLD.
- Address boundaries:
  - cpu_addr = BASE_ADDR + 2^MEM_LOG2 - 1 is a hit; ram_addr = all ones.
  - BASE_ADDR + 2^MEM_LOG2 is a miss.
  - With a nonzero BASE_ADDR, addresses below the base wrap to large values and miss.

Test Plan:
- Hold ram_loaded=0 for 4096 cycles after n_reset rises -> cpu_n_reset=0 and ram_ce=0 throughout. Raise ram_loaded -> cpu_n_reset=1 one cycle later.
- Read 16'h0123 with the RAM model returning 8'h3E -> ram_ce pulses 1 cycle with ram_addr=12'h123; wait_n low 2 cycles; cpu_din=8'h3E as wait_n rises.
- Read 16'h0FFF -> hit, ram_addr=12'hFFF. Read 16'h1000 -> no ram_ce, wait_n stays 1, cpu_din=8'hFF.
- Write 16'h0040 -> wr_err pulses once, ram_ce stays 0. Write 16'h8000 -> wr_err stays 0.
- Hold mreq_n low for 5 cycles after data capture -> exactly one ram_ce pulse. Deassert, re-request -> a second pulse.
- Assert n_reset low during FETCH -> all outputs at reset values immediately; after release, BOOT is re-entered and cpu_n_reset waits for ram_loaded.
